// File: rtl/mips_cpu_bus_pkg.sv
// mips_cpu_bus_pkg: shared types and constants for the CPU bus arbiter.
package mips_cpu_bus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} bus_state_t;
  typedef enum logic {PORT_I, PORT_D} bus_port_t;
  localparam logic [3:0] BUS_BE_FULL = 4'b1111;
  localparam int LAT_W = 2;
endpackage

// File: rtl/mips_cpu_bus_arb_pick.sv
// mips_cpu_bus_arb_pick: grant selection between fetch and data ports.
// MIPS_BUS_ARB_RR_EN selects round-robin; otherwise fixed data-over-fetch.
module mips_cpu_bus_arb_pick
  import mips_cpu_bus_pkg::*;
(
  input  logic      valid_i,
  input  logic      valid_d,
`ifdef MIPS_BUS_ARB_RR_EN
  input  bus_port_t last,
`endif
  output bus_port_t grant
);
`ifdef MIPS_BUS_ARB_RR_EN
  assign grant = (valid_i && valid_d) ? ((last == PORT_D) ? PORT_I : PORT_D)
                                      : (valid_i ? PORT_I : PORT_D);
`else
  assign grant = (valid_d || !valid_i) ? PORT_D : PORT_I;
`endif
endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: serialises fetch and data requests onto one CPU bus.
// Define MIPS_BUS_ARB_RR_EN for round-robin arbitration.
module mips_cpu_bus_arbiter
  import mips_cpu_bus_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_byteenable,
  input  logic [31:0]       i_writedata,
  output logic              i_waitrequest,
  output logic [31:0]       i_readdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_byteenable,
  input  logic [31:0]       d_writedata,
  output logic              d_waitrequest,
  output logic [31:0]       d_readdata,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata
);
  bus_state_t state, state_nx;
  bus_port_t owner, grant;
  logic [LAT_W-1:0] cnt;
  logic valid_i, valid_d, gd, start;
  assign valid_i = i_read ^ i_write;
  assign valid_d = d_read ^ d_write;
  assign start = state == IDLE && (valid_i || valid_d);
  assign gd = grant == PORT_D;
  // The latched owner doubles as the round-robin "last granted" pointer
`ifdef MIPS_BUS_ARB_RR_EN
  mips_cpu_bus_arb_pick u_pick (.valid_i(valid_i), .valid_d(valid_d), .last(owner), .grant(grant));
`else
  mips_cpu_bus_arb_pick u_pick (.valid_i(valid_i), .valid_d(valid_d), .grant(grant));
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   state_nx = start ? ISSUE : IDLE;
      ISSUE:  state_nx = m_waitrequest ? ISSUE : (m_read ? RDWAIT : DONE);
      RDWAIT: state_nx = (cnt == '0) ? DONE : RDWAIT;
      DONE:   state_nx = IDLE;
    endcase
  end
  always_comb begin
    i_waitrequest = valid_i && !(state == DONE && owner == PORT_I);
    d_waitrequest = valid_d && !(state == DONE && owner == PORT_D);
  end
  always_ff @(posedge clk)
    if (reset) begin
      owner        <= PORT_I;
      cnt          <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_addr       <= '0;
      m_byteenable <= '0;
      m_writedata  <= '0;
      i_readdata   <= '0;
      d_readdata   <= '0;
    end else begin
      if (start) begin
        owner        <= grant;
        m_read       <= gd ? d_read : i_read;
        m_write      <= gd ? d_write : i_write;
        m_addr       <= gd ? d_addr : i_addr;
        m_byteenable <= gd ? d_byteenable : i_byteenable;
        m_writedata  <= gd ? d_writedata : i_writedata;
      end
      if (state == ISSUE && !m_waitrequest) begin
        m_read  <= 1'b0;
        m_write <= 1'b0;
        cnt     <= LAT_W'(READ_LATENCY - 1);
      end
      if (state == RDWAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0 && owner == PORT_I) i_readdata <= m_readdata;
        if (cnt == '0 && owner == PORT_D) d_readdata <= m_readdata;
      end
    end
endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// tb_mips_cpu_bus_arbiter: directed self-checking bench with a latency-1 bus memory.
module tb_mips_cpu_bus_arbiter;
  import mips_cpu_bus_pkg::*;
  logic clk, reset;
  logic i_read, i_write, i_waitrequest, d_read, d_write, d_waitrequest;
  logic [31:0] i_addr, i_writedata, i_readdata, d_addr, d_writedata, d_readdata;
  logic [3:0] i_byteenable, d_byteenable, m_byteenable;
  logic m_read, m_write, m_waitrequest;
  logic [31:0] m_addr, m_writedata, m_readdata;
  logic [31:0] mem [256] = '{4: 32'h2402000F, default: 32'h0};
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int s, t, got, exp;

  mips_cpu_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_byteenable(i_byteenable),
    .i_writedata(i_writedata), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_byteenable(d_byteenable),
    .d_writedata(d_writedata), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_byteenable(m_byteenable),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (m_write && !m_waitrequest) mem[m_addr[9:2]] <= m_writedata;
    if (m_read && !m_waitrequest) m_readdata <= mem[m_addr[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic at_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_low(input bit dport, output int tc);
    tc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dport ? !d_waitrequest : !i_waitrequest) begin
        tc = cyc;
        break;
      end
    end
    if (tc < 0) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    {i_read, i_write, d_read, d_write, m_waitrequest} = '0;
    {i_addr, i_writedata, d_addr, d_writedata} = '0;
    i_byteenable = BUS_BE_FULL;
    d_byteenable = BUS_BE_FULL;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mread", m_read, 0);
    check("rst_mwrite", m_write, 0);
    check("rst_maddr", m_addr, 0);
    check("rst_irdata", i_readdata, 0);
    check("rst_drdata", d_readdata, 0);
    check("rst_iwait", i_waitrequest, 0);

    at_edge();
    i_read = 1'b1; i_addr = 32'h10; s = cyc;
    @(negedge clk);
    check("t1_stall", i_waitrequest, 1);
    @(negedge clk);
    check("t1_mread", m_read, 1);
    check("t1_maddr", m_addr, 32'h10);
    check("t1_be", m_byteenable, 4'hF);
    wait_low(0, t);
    check("t1_lat", t - s, 3);
    check("t1_data", i_readdata, 32'h2402000F);
    at_edge();
    i_read = 1'b0;

    at_edge();
    d_write = 1'b1; d_addr = 32'h100; d_writedata = 32'hDEADBEEF;
    i_read = 1'b1; i_addr = 32'h100; s = cyc;
    @(negedge clk);
    @(negedge clk);
    check("t2_mwrite", m_write, 1);
    check("t2_mread", m_read, 0);
    check("t2_wdata", m_writedata, 32'hDEADBEEF);
    wait_low(1, t);
    check("t2_dlat", t - s, 2);
    check("t2_istall", i_waitrequest, 1);
    at_edge();
    d_write = 1'b0;
    wait_low(0, t);
    check("t2_ilat", t - s, 6);
    check("t2_rdback", i_readdata, 32'hDEADBEEF);
    at_edge();
    i_read = 1'b0;

    at_edge();
    d_read = 1'b1; d_addr = 32'h100; i_read = 1'b1; i_addr = 32'h10;
    for (int k = 0; k < 6; k++) begin
      got = -1;
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        if (!d_waitrequest) begin got = 1; break; end
        if (!i_waitrequest) begin got = 0; break; end
      end
`ifdef MIPS_BUS_ARB_RR_EN
      exp = (k % 2 == 0) ? 1 : 0;
`else
      exp = 1;
`endif
      check($sformatf("t3_grant%0d", k), got, exp);
    end
    at_edge();
    d_read = 1'b0; i_read = 1'b0;

    at_edge();
    d_read = 1'b1; d_addr = 32'h100; m_waitrequest = 1'b1; s = cyc;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("t4_mread%0d", k), m_read, 1);
      check($sformatf("t4_maddr%0d", k), m_addr, 32'h100);
    end
    at_edge();
    m_waitrequest = 1'b0;
    wait_low(1, t);
    check("t4_lat", t - s, 6);
    check("t4_data", d_readdata, 32'hDEADBEEF);
    at_edge();
    d_read = 1'b0;

    at_edge();
    i_read = 1'b1; i_addr = 32'h10; s = cyc;
    @(negedge clk);
    @(negedge clk);
    check("t5_issue", m_read, 1);
    at_edge();
    reset = 1'b1;
    at_edge();
    reset = 1'b0;
    @(negedge clk);
    check("t5_mread", m_read, 0);
    check("t5_irdata", i_readdata, 0);
    check("t5_drdata", d_readdata, 0);
    check("t5_iwait", i_waitrequest, 1);
    @(negedge clk);
    check("t5_reissue", m_read, 1);
    wait_low(0, t);
    check("t5_lat", t - s, 6);
    check("t5_data", i_readdata, 32'h2402000F);
    at_edge();
    i_read = 1'b0;

    at_edge();
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h100; d_writedata = 32'h12345678;
    i_read = 1'b1; i_addr = 32'h10; s = cyc;
    @(negedge clk);
    check("t6_dwait", d_waitrequest, 0);
    check("t6_iwait", i_waitrequest, 1);
    @(negedge clk);
    check("t6_mwrite", m_write, 0);
    check("t6_mread", m_read, 1);
    check("t6_maddr", m_addr, 32'h10);
    wait_low(0, t);
    check("t6_lat", t - s, 3);
    check("t6_data", i_readdata, 32'h2402000F);
    check("t6_dwait_done", d_waitrequest, 0);
    at_edge();
    {i_read, d_read, d_write} = '0;
    @(negedge clk);
    check("t6_mem", mem[64], 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_cpu_bus_arbiter.md
# mips_cpu_bus_arbiter

Two-port arbiter sharing the single CPU memory bus between the instruction-fetch port and the data (load/store) port of the MIPS core. It serialises transactions onto the bus, honours bus `waitrequest`, and captures read data after a fixed read latency. It returns read data or write completion to the owning requester. It sits between the core's fetch/LSU logic and `mips_cpu_bus_memory` (or the top-level Avalon bus).

## Interface
Parameters:
- `ADDR_W`, 32, address width on requester and bus sides.
- `READ_LATENCY`, 1, cycles from bus read acceptance to valid `m_readdata`; legal range 1..3.

Ports:
- One clock; reset is synchronous and active-high. The clock port is `clk` and the reset port is `reset`.
- `clk`  in  1  clock.
- `reset`  in  1  sync active-high reset.
- `i_read`, `i_write`  in  1  fetch-port requests.
- `i_addr`  in  ADDR_W  fetch address.
- `i_byteenable`  in  4  fetch byte enables.
- `i_writedata`  in  32  fetch write data (unused by the core, still arbitrated).
- `i_waitrequest`  out  1  fetch stall.
- `i_readdata`  out  32  fetch read data.
- `d_read`, `d_write`, `d_addr`, `d_byteenable`, `d_writedata`, `d_waitrequest`, `d_readdata`: data port, identical in width and meaning to the fetch port.
- `m_read`, `m_write`  out  1  bus commands.
- `m_addr`  out  ADDR_W  bus address.
- `m_byteenable`  out  4  bus byte enables.
- `m_writedata`  out  32  bus write data.
- `m_waitrequest`  in  1  bus stall.
- `m_readdata`  in  32  bus read data.

## Operation
- **Valid request:** a port has a valid request when `read XOR write` is high. `read&&write` on a port is ignored: that port's waitrequest stays low and it is never granted.
- **Requester waitrequest:** `p_waitrequest = valid_p && !(state==DONE && owner==p)`. This is combinational, so a requester stalls in the same cycle it asserts its request.
- **FSM states:**
  - IDLE: if any valid request, pick owner, register cmd/addr/be/wdata onto `m_*`, go to ISSUE.
  - ISSUE: hold `m_*` stable while `m_waitrequest` is high. On a cycle with `m_waitrequest` low, a write goes to DONE and a read goes to RDWAIT with latency counter = READ_LATENCY-1. `m_read`/`m_write` drop on leaving ISSUE.
  - RDWAIT: decrement the counter. At 0, capture `m_readdata` into the owner's readdata register and go to DONE.
  - DONE: owner's waitrequest is low for exactly one cycle, then return to IDLE.
- **Priority:** default is fixed priority, data over fetch. Grants are decided only in IDLE; there is no pre-emption.
- **Latching:** request fields are latched at grant. Requesters hold them anyway per bus rules; changes after grant are ignored.
- **readdata registers:** `i_readdata`/`d_readdata` hold their last captured value until that port's next read completes. Writes leave them unchanged.
- **Reset values:** all `m_*` = 0, both readdata = 0, state = IDLE, round-robin pointer favours data.
- **Reset mid-transaction:** the transaction is abandoned and `m_read`/`m_write` are low from the next cycle. A requester still asserting its request sees waitrequest high and is re-arbitrated.

## Timing
- Request first seen in IDLE cycle N gives bus command in cycle N+1.
- With zero bus wait states:
  - Read: DONE in cycle N+2+READ_LATENCY (N+3 at the default latency).
  - Write: DONE in cycle N+2.
- Each bus wait-state cycle adds one cycle.
- Back-to-back: the earliest next grant is evaluated in the IDLE cycle right after DONE. The minimum gap between bus commands is 2 cycles for writes.
- Requests arriving during a busy transaction wait. In the IDLE after DONE, both pending ports are resolved by the priority rule.

## Configuration
- `MIPS_BUS_ARB_RR_EN` defined: round-robin arbitration. The port granted last has the lower priority at the next IDLE with both ports valid. A single requester is always granted.
- `MIPS_BUS_ARB_RR_EN` undefined: fixed data-over-fetch priority. The pointer logic is not built.

## Structure
- Package `mips_cpu_bus_pkg`:
  - `bus_state_t` enum (IDLE, ISSUE, RDWAIT, DONE).
  - `bus_port_t` enum (PORT_I, PORT_D).
  - `BUS_BE_FULL = 4'b1111`.
  - Latency counter width constant.
- Sub-module `mips_cpu_bus_arb_pick`: combinational grant selection from the two valid bits plus the last-owner pointer, `ifdef`-switched by the macro.

## Test plan
- **Single fetch read:** `i_read`, addr 0x000010, be 1111, memory word 0x2402000F → `m_read` in cycle N+1; `i_readdata` = 0x2402000F with `i_waitrequest` low in N+3.
- **Simultaneous requests:** `d_write` to 0x100 (0xDEADBEEF, be 1111) and `i_read` at the same time → data granted first. Fixed build: fetch granted in the IDLE after data DONE; the memory word at 0x100 reads back 0xDEADBEEF.
- **Repeated contention:**
  - RR build: both ports request continuously for 6 transactions → grants alternate D, I, D, I, D, I.
  - Fixed build: with the data port always requesting, fetch starves.
- **Bus wait states:** `m_waitrequest` high for 3 cycles during a data read → `m_*` stable for all 3 cycles; DONE delayed by exactly 3 cycles.
- **Reset mid-read:** `reset` pulsed in RDWAIT → next cycle `m_read` = 0, readdata = 0, state IDLE. The request still held is re-issued 1 cycle after reset deasserts.
- **Illegal request:** `d_read` and `d_write` both high → `d_waitrequest` = 0, no bus command issued, fetch traffic unaffected.
